// File: rtl/divider_reconstruct_pipe_if.sv
// Streaming operand/result bundle for divider_reconstruct_pipe.
// out_err is only present when DIVRECON_CHECK_EN is defined.
interface divider_reconstruct_pipe_if #(
   parameter int unsigned DIVIDENDLEN = 16,
   parameter int unsigned DIVISORLEN  = 8
);
   localparam int unsigned PRODLEN = DIVIDENDLEN + DIVISORLEN;

   logic                   in_valid;
   logic                   in_ready;
   logic [DIVIDENDLEN-1:0] qin;
   logic [DIVISORLEN-1:0]  divin;
   logic [DIVISORLEN-1:0]  remin;
   logic                   out_valid;
   logic                   out_ready;
   logic [PRODLEN-1:0]     dout;
`ifdef DIVRECON_CHECK_EN
   logic                   out_err;
`endif

   modport master (
`ifdef DIVRECON_CHECK_EN
      input  out_err,
`endif
      output in_valid, qin, divin, remin, out_ready,
      input  in_ready, out_valid, dout
   );

   modport slave (
`ifdef DIVRECON_CHECK_EN
      output out_err,
`endif
      input  in_valid, qin, divin, remin, out_ready,
      output in_ready, out_valid, dout
   );
endinterface

// File: rtl/divider_reconstruct_pipe.sv
// Pipelined dividend rebuild: dout = quotient*divisor + remainder, one shift-add stage per quotient bit, MSB first.
// Optional consistency flag out_err under macro DIVRECON_CHECK_EN.
module divider_reconstruct_pipe #(
   parameter int unsigned DIVIDENDLEN = 16,
   parameter int unsigned DIVISORLEN  = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   divider_reconstruct_pipe_if.slave bus
);
   localparam int unsigned PRODLEN = DIVIDENDLEN + DIVISORLEN;
   localparam int unsigned NS      = DIVIDENDLEN;

   // Register j holds the partial sum after quotient bit NS-1-j; the last stage needs no operands.
   logic                   valid [NS];
   logic [PRODLEN-1:0]     acc   [NS];
   logic [DIVISORLEN-1:0]  dv    [NS-1];
   logic [DIVIDENDLEN-1:0] qrem  [NS-1];
   logic                   stall;

   function automatic logic [PRODLEN-1:0] term(input logic qbit,
                                               input logic [DIVISORLEN-1:0] d,
                                               input int unsigned k);
      return qbit ? (PRODLEN'(d) << k) : '0;
   endfunction

   assign stall         = valid[NS-1] && !bus.out_ready;
   assign bus.in_ready  = !stall;
   assign bus.out_valid = valid[NS-1];
   assign bus.dout      = acc[NS-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned j = 0; j < NS; j++) begin
            valid[j] <= 1'b0;
            acc[j]   <= '0;
         end
         for (int unsigned j = 0; j < NS - 1; j++) begin
            dv[j]   <= '0;
            qrem[j] <= '0;
         end
      end else if (!stall) begin
         valid[0] <= bus.in_valid;
         acc[0]   <= PRODLEN'(bus.remin) + term(bus.qin[NS-1], bus.divin, NS - 1);
         dv[0]    <= bus.divin;
         qrem[0]  <= bus.qin << 1;
         for (int unsigned j = 1; j < NS; j++) begin
            valid[j] <= valid[j-1];
            acc[j]   <= acc[j-1] + term(qrem[j-1][NS-1], dv[j-1], NS - 1 - j);
         end
         // Quotient is consumed from the top, so each stage shifts the used bit out.
         for (int unsigned j = 1; j < NS - 1; j++) begin
            dv[j]   <= dv[j-1];
            qrem[j] <= qrem[j-1] << 1;
         end
      end
   end

`ifdef DIVRECON_CHECK_EN
   logic err [NS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned j = 0; j < NS; j++) err[j] <= 1'b0;
      end else if (!stall) begin
         err[0] <= (bus.remin >= bus.divin);
         for (int unsigned j = 1; j < NS; j++) err[j] <= err[j-1];
      end
   end

   // Overflow half of the check needs the finished sum, so it is evaluated at the output.
   assign bus.out_err = valid[NS-1] && (err[NS-1] || (|acc[NS-1][PRODLEN-1:DIVIDENDLEN]));
`endif
endmodule
